// File: rtl/fir_stage3_cic.sv
// Third DAC interpolation stage: 3-stage CIC interpolator, factor R.
// Valid-strobed input replaces zero-stuffing; R outputs per accepted sample.
module fir_stage3_cic #(
  parameter int R = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din_valid,
  input  logic signed [15:0] data_in,
  output logic signed [15:0] data_out,
  output logic               dout_valid,
  output logic               busy,
  output logic               overrun
);

  localparam int LR = $clog2(R);
  localparam int W  = 16 + 3 * LR;
  localparam int S  = 2 * LR;
  localparam int CW = $clog2(R + 1);

  localparam logic [CW-1:0] RC  = CW'(R);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [W:0] HALF =
    {{(W-S+1){1'b0}}, 1'b1, {(S-1){1'b0}}};

  logic [CW-1:0]       r_cnt;
  logic signed [W-1:0] r_xd;
  logic signed [W-1:0] r_c1d;
  logic signed [W-1:0] r_c2d;
  logic signed [W-1:0] r_c;
  logic signed [W-1:0] r_i1;
  logic signed [W-1:0] r_i2;
  logic signed [W-1:0] r_i3;
  logic signed [15:0]  r_dout;
  logic                r_dv;
  logic                r_ovr;

  logic                w_acc;
  logic                w_drop;
  logic                w_act;
  logic signed [W-1:0] w_x;
  logic signed [W-1:0] w_c1;
  logic signed [W-1:0] w_c2;
  logic signed [W-1:0] w_c3;
  logic signed [W-1:0] w_u;
  logic signed [W-1:0] w_i1;
  logic signed [W-1:0] w_i2;
  logic signed [W-1:0] w_i3;
  logic signed [W:0]   w_rnd;
  logic signed [W:0]   w_sh;
  logic                w_fit;
  logic signed [15:0]  w_y;

  assign w_acc  = din_valid && (r_cnt <= ONE);
  assign w_drop = din_valid && !w_acc;
  assign w_act  = (r_cnt != '0);

  assign w_x  = {{(W-16){data_in[15]}}, data_in};
  assign w_c1 = w_x - r_xd;
  assign w_c2 = w_c1 - r_c1d;
  assign w_c3 = w_c2 - r_c2d;

  // Only the first phase of a burst carries the comb output.
  assign w_u  = (r_cnt == RC) ? r_c : '0;
  assign w_i1 = r_i1 + w_u;
  assign w_i2 = r_i2 + w_i1;
  assign w_i3 = r_i3 + w_i2;

  assign w_rnd = {w_i3[W-1], w_i3} + HALF;
  assign w_sh  = w_rnd >>> S;
  assign w_fit = (w_sh[W:15] == '0) || (w_sh[W:15] == '1);
  assign w_y   = w_fit ? w_sh[15:0]
               : (w_sh[W] ? 16'sh8000 : 16'sh7fff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_xd   <= '0;
      r_c1d  <= '0;
      r_c2d  <= '0;
      r_c    <= '0;
      r_i1   <= '0;
      r_i2   <= '0;
      r_i3   <= '0;
      r_dout <= '0;
      r_dv   <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_acc) begin
        r_xd  <= w_x;
        r_c1d <= w_c1;
        r_c2d <= w_c2;
        r_c   <= w_c3;
      end
      if (w_drop) r_ovr <= 1'b1;
      r_dv <= w_act;
      if (w_act) begin
        r_i1   <= w_i1;
        r_i2   <= w_i2;
        r_i3   <= w_i3;
        r_dout <= w_y;
      end
      if (w_acc) r_cnt <= RC;
      else if (w_act) r_cnt <= r_cnt - ONE;
    end
  end

  assign data_out   = r_dout;
  assign dout_valid = r_dv;
  assign busy       = w_act;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_fir_stage3_cic.sv
// Scoreboard bench for fir_stage3_cic (R=4) with directed vectors.
// Expected outputs are hand-computed tables queued at stimulus time.
module tb_fir_stage3_cic;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               din_valid = 1'b0;
  logic signed [15:0] data_in = '0;
  logic signed [15:0] data_out;
  logic               dout_valid;
  logic               busy;
  logic               overrun;

  fir_stage3_cic #(.R(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .data_in    (data_in),
    .data_out   (data_out),
    .dout_valid (dout_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int run = 0;
  int maxrun = 0;
  logic chk_hold = 1'b0;
  logic b_after = 1'b0;
  logic signed [15:0] last = '0;
  logic signed [15:0] e_mon;
  int expq[$];

  int imp_t[16] = '{1024, 3072, 6144, 10240, 12288, 12288, 10240,
                    6144, 3072, 1024, 0, 0, 0, 0, 0, 0};
  int dc_t[10]  = '{63, 188, 375, 625, 813, 938, 1000, 1000, 1000, 1000};
  int fsp_t[7]  = '{2048, 6144, 12288, 20479, 26623, 30719, 32767};
  int fsn_t[7]  = '{28671, 20479, 8191, -8192, -20480, -28672, -32768};

  task automatic check(input string name, input longint act,
                       input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && dout_valid) begin
      run++;
      if (run > maxrun) maxrun = run;
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_out: got %0d want none", data_out);
      end else begin
        e_mon = 16'(expq.pop_front());
        check("data_out", data_out, e_mon);
      end
      last = data_out;
    end else begin
      run = 0;
      if (chk_hold) check("idle_hold", data_out, last);
    end
  end

  task automatic strobe(input logic signed [15:0] v, input int gap);
    din_valid = 1'b1;
    data_in = v;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    data_in = '0;
    b_after = busy;
    repeat (gap - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_drained"}, expq.size(), 0);
    expq.delete();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_data", data_out, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);
    expq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    #1;
    do_reset();

    for (int i = 0; i < 16; i++) expq.push_back(imp_t[i]);
    strobe(16384, 4);
    check("busy_after_accept", b_after, 1);
    for (int i = 0; i < 3; i++) strobe(0, 4);
    drain("impulse");
    check("busy_idle", busy, 0);

    do_reset();
    maxrun = 0;
    for (int i = 0; i < 24; i++) expq.push_back(i < 10 ? dc_t[i] : 1000);
    for (int i = 0; i < 6; i++) strobe(1000, 4);
    drain("dc");
    check("dc_run", maxrun, 24);

    do_reset();
    maxrun = 0;
    for (int i = 0; i < 24; i++) expq.push_back(i < 7 ? fsp_t[i] : 32767);
    for (int i = 0; i < 24; i++) expq.push_back(i < 7 ? fsn_t[i] : -32768);
    for (int i = 0; i < 6; i++) strobe(16'sh7fff, 4);
    for (int i = 0; i < 6; i++) strobe(16'sh8000, 4);
    drain("fullscale");
    check("fs_run", maxrun, 48);

    do_reset();
    for (int i = 0; i < 16; i++) expq.push_back(imp_t[i]);
    strobe(16384, 2);
    check("ovr_before", overrun, 0);
    strobe(5000, 2);
    check("ovr_set", overrun, 1);
    for (int i = 0; i < 3; i++) strobe(0, 4);
    drain("overrun");
    check("ovr_sticky", overrun, 1);

    do_reset();
    expq.push_back(1024);
    expq.push_back(3072);
    din_valid = 1'b1;
    data_in = 16384;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    data_in = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", data_out, 0);
    check("mid_rst_valid", dout_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pending", expq.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 16; i++) expq.push_back(imp_t[i]);
    strobe(16384, 4);
    for (int i = 0; i < 3; i++) strobe(0, 4);
    drain("post_reset");

    do_reset();
    maxrun = 0;
    for (int i = 0; i < 20; i++) expq.push_back(i < 10 ? dc_t[i] : 1000);
    strobe(1000, 7);
    chk_hold = 1'b1;
    for (int i = 0; i < 4; i++) strobe(1000, 7);
    chk_hold = 1'b0;
    drain("gapped");
    check("gap_run", maxrun, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_stage3_cic.md
# fir_stage3_cic

Third interpolation stage of the wavelength-locker DAC path: a 3-stage CIC interpolator that takes the 16-bit samples produced by `fir_stage2` and raises the rate by R. Each accepted input sample yields R output samples on consecutive clocks. The block uses a valid strobe in place of external zero-stuffing. The system clock must run at least R times the stage-2 output rate.

## Interface
- `R`, default 4, interpolation factor; legal values 2, 4, 8, 16 (power of two); differential delay fixed at 1, stage count N fixed at 3.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din_valid`  in  1  one-clock strobe; `data_in` is offered this cycle.
- `data_in`  in  16  signed two's-complement stage-2 sample.
- `data_out`  out  16  signed interpolated sample.
- `dout_valid`  out  1  high for each clock carrying a new `data_out`.
- `busy`  out  1  high while the phase counter is nonzero.
- `overrun`  out  1  sticky; set when an offered sample is dropped; cleared only by reset.

## Operation
- Internal width W = 16 + 3·log2(R) (22 for R=4). All combs and integrators are W-bit signed; integrator overflow wraps modulo 2^W, as required for CIC.
- Phase counter `cnt`, range 0..R. The block accepts a sample when `din_valid && cnt <= 1`.
- On accept:
  - Comb chain c1 = x − x_d, c2 = c1 − c1_d, c3 = c2 − c2_d is evaluated from sign-extended `data_in`.
  - c3 is registered as `c`. Comb delay registers update only on accept.
  - `cnt` is loaded with R.
- On every edge with `cnt > 0`:
  - Integrator input u = c when `cnt == R`, else 0 (zero-stuffing).
  - Integrators update as a chained same-cycle sum: i1 += u; i2 += i1_new; i3 += i2_new.
  - `data_out` is registered from i3_new, scaled as described below.
  - `cnt` decrements, unless an accept happens on the same edge (`cnt == 1` with `din_valid`), in which case `cnt` reloads to R.
- Scaling:
  - S = 2·log2(R). DC gain R^2 is removed.
  - y = (i3_new + 2^(S−1)) >>> S (round half up).
  - y saturates to [−32768, 32767] before registering.
- Drop rule: if `din_valid` arrives with `cnt >= 2`, the sample is ignored, no state changes, and `overrun` is set to 1.
- Simultaneous accept and last phase:
  - The final integration of the old sample uses u = 0.
  - The new `c` is loaded on the same edge.
  - The stream continues gap-free.

## Timing
- Reset (async assert): `data_out`=0, `dout_valid`=0, `busy`=0, `overrun`=0, `cnt`=0. All comb, delay and integrator registers are 0.
- Accept at edge k: `dout_valid` is high after edges k+1 … k+R (R cycles). The first output, latency 1 clock, reflects sample k.
- `busy` is high after edge k until the edge at which `cnt` reaches 0.
- With `din_valid` exactly every R clocks, `dout_valid` stays continuously high.
- Gaps longer than R clocks give `dout_valid` low while `cnt` = 0. Integrators hold their state during the gap.
- `rst_n` asserted mid-burst: all state clears immediately. The remaining phases of that burst are not emitted.
- After release, the first `din_valid` is accepted normally with zero history.

## Test plan
- DC: `data_in`=1000 strobed every 4 clocks (R=4) → after the 10-output transient, `data_out`=1000 on every clock and `dout_valid` stays continuously high.
- Impulse: 16384 once, then zeros every 4 clocks → `data_out` = 1024, 3072, 6144, 10240, 12288, 12288, 10240, 6144, 3072, 1024, then 0.
- Full scale: DC +32767, then DC −32768 → steady outputs are exactly 32767 and −32768, with no wrap.
- Overrun: `din_valid` at edges 0 and 2 → the second sample is dropped and `overrun`=1. The output equals the single-sample response, and `overrun` holds until reset.
- Reset mid-burst: assert `rst_n`=0 after the second output of an impulse burst → all outputs are 0 immediately. After release, a new impulse reproduces the clean impulse sequence.
- Gapped input: DC 1000 strobed every 7 clocks → 4 valid outputs per strobe, 3 idle cycles with `dout_valid`=0 and `data_out` held, and the steady value is still 1000.
